mssb_idx: RTL and testbench

//   Most-significant-set-bit index encoder, registered output. Reports the bit

---
 rtl/mssb_idx.sv | 76 +++++++
 tb/tb_mssb_idx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mssb_idx.sv
// Most-significant-set-bit index encoder with one register stage.
// A balanced tree of (valid, index) merge nodes feeds a clock-gated output flop pair.
module mssb_idx #(
  parameter  int WIDTH = 16,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cg,
  input  logic [WIDTH-1:0]  i_vector,
  output logic [IDXW-1:0]   o_index,
  output logic              o_valid
);

  localparam int PW = 1 << IDXW;

  // Level 0 holds the padded leaves; level IDXW is the single root node.
  // Each level halves the node count, and a node takes its upper child
  // whenever that child is valid.
  for (genvar lvl = 0; lvl <= IDXW; lvl++) begin : g_lvl
    localparam int N = PW >> lvl;
    logic [N-1:0]    v;
    logic [IDXW-1:0] ix [N];

    if (lvl == 0) begin : g_leaf
      for (genvar n = 0; n < PW; n++) begin : g_bit
        // Padding leaves are never valid, so their index can never win.
        if (n < WIDTH) begin : g_real
          assign v[n] = i_vector[n];
        end else begin : g_pad
          assign v[n] = 1'b0;
        end
        assign ix[n] = IDXW'(n);
      end
    end else begin : g_merge
      for (genvar m = 0; m < N; m++) begin : g_node
        assign v[m]  = g_lvl[lvl-1].v[2*m+1] | g_lvl[lvl-1].v[2*m];
        assign ix[m] = g_lvl[lvl-1].v[2*m+1] ? g_lvl[lvl-1].ix[2*m+1]
                                             : g_lvl[lvl-1].ix[2*m];
      end
    end
  end

  logic            enc_valid;
  logic [IDXW-1:0] enc_index;

  assign enc_valid = g_lvl[IDXW].v[0];
  assign enc_index = enc_valid ? g_lvl[IDXW].ix[0] : '0;

  logic [IDXW-1:0] index_d, index_q;
  logic            valid_d, valid_q;

  always_comb begin
    index_d = index_q;
    valid_d = valid_q;
    if (i_cg) begin
      index_d = enc_index;
      valid_d = enc_valid;
    end
  end

  // Reset wins over the clock gate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  assign o_index = index_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mssb_idx.sv
// Bench for mssb_idx: WIDTH=16, 9 and 7 instances driven in lock-step and
// checked against a bit-scan reference model through an expected queue.
module tb_mssb_idx;

  logic        clk;
  logic        rst;
  logic        cg;
  logic [15:0] vec16;
  logic [8:0]  vec9;
  logic [6:0]  vec7;

  logic [3:0]  idx16;
  logic [3:0]  idx9;
  logic [2:0]  idx7;
  logic        vld16, vld9, vld7;

  mssb_idx #(.WIDTH(16)) u_w16 (.i_clk(clk), .i_rst(rst), .i_cg(cg), .i_vector(vec16),
                                .o_index(idx16), .o_valid(vld16));
  mssb_idx #(.WIDTH(9))  u_w9  (.i_clk(clk), .i_rst(rst), .i_cg(cg), .i_vector(vec9),
                                .o_index(idx9), .o_valid(vld9));
  mssb_idx #(.WIDTH(7))  u_w7  (.i_clk(clk), .i_rst(rst), .i_cg(cg), .i_vector(vec7),
                                .o_index(idx7), .o_valid(vld7));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed results packed as {valid, index} per instance.
  logic [4:0] got [3];
  assign got[0] = {vld16, idx16};
  assign got[1] = {vld9, idx9};
  assign got[2] = {vld7, 1'b0, idx7};

  int          widths [3] = '{16, 9, 7};
  logic [4:0]  exp_q [3][$];
  logic [4:0]  model_state [3];
  logic [4:0]  exp_v;
  int          n_total = 0;
  int          n_bad   = 0;

  function automatic logic [4:0] ref_msb(input logic [15:0] v, input int w);
    logic [4:0] r;
    r = 5'd0;
    for (int n = 0; n < w; n++)
      if (v[n]) r = {1'b1, 4'(n)};
    return r;
  endfunction

  // Driver: applies one cycle of stimulus, pushes the expected register
  // contents, then returns at the following falling edge for sampling.
  task automatic drive(input logic [15:0] v, input logic c, input logic r);
    vec16 = v;
    vec9  = v[8:0];
    vec7  = v[6:0];
    cg    = c;
    rst   = r;
    for (int i = 0; i < 3; i++) begin
      if (r)      model_state[i] = 5'd0;
      else if (c) model_state[i] = ref_msb(v, widths[i]);
      exp_q[i].push_back(model_state[i]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(16'hFFFF, 1'b1, 1'b1);
      else       drive(16'hFFFF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL reset w%0d cyc=%0d got=%h exp=%h", widths[i], c, got[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_zero_lsb();
    logic [15:0] pats [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001};
    for (int p = 0; p < 4; p++) begin
      drive(pats[p], 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL zero_lsb w%0d vec=%h got=%h exp=%h", widths[i], pats[p], got[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_walking_one();
    for (int k = 0; k < 16; k++) begin
      drive(16'(1 << k), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL walk w%0d k=%0d got=%h exp=%h", widths[i], k, got[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [15:0] pats [3] = '{16'h0F0F, 16'h00A5, 16'h0015};
    int          msbs [3] = '{15, 8, 6};
    logic [15:0] v;
    for (int p = 0; p < 3 + 3 * 6; p++) begin
      if (p < 3) begin
        v = pats[p];
      end else begin
        // Fixed top bit with random noise underneath.
        v = 16'(1 << msbs[(p - 3) % 3]);
        v = v | (16'($urandom_range(0, 65535)) & (v - 16'd1));
      end
      drive(v, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL priority w%0d vec=%h got=%h exp=%h", widths[i], v, got[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 65536; v++) begin
      drive(16'(v), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL exhaustive w%0d vec=%h got=%h exp=%h", widths[i], v[15:0], got[i], exp_v);
        end
      end
    end
  endtask

  task automatic test_gating();
    logic [15:0] v;
    logic        c, r;
    // Load, hold 3 cycles under changing input, reset while gated, reload.
    for (int s = 0; s < 7; s++) begin
      v = 16'($urandom_range(1, 65535));
      c = 1'b0;
      r = 1'b0;
      case (s)
        0:       begin v = 16'h0F0F; c = 1'b1; end
        4:       r = 1'b1;
        6:       c = 1'b1;
        default: ;
      endcase
      drive(v, c, r);
      for (int i = 0; i < 3; i++) begin
        exp_v = exp_q[i].pop_front();
        n_total++;
        if (got[i] !== exp_v) begin
          n_bad++;
          $display("FAIL gating w%0d step=%0d vec=%h got=%h exp=%h", widths[i], s, v, got[i], exp_v);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    cg    = 1'b0;
    vec16 = '0;
    vec9  = '0;
    vec7  = '0;
    for (int i = 0; i < 3; i++) model_state[i] = 5'd0;
    @(negedge clk);
    test_reset();
    test_zero_lsb();
    test_walking_one();
    test_priority();
    test_gating();
    test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (exp_q[i].size() != 0) begin
        n_bad++;
        $display("FAIL queue_drain w%0d left=%0d exp=0", widths[i], exp_q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
